neuro_mem_responder: RTL and testbench

// - Memory-side responder for the tagged read interface driven by the Neuro32 accumulator and similar cores
//   (ACT/NEXT/SEL/OFFSET/SIZE/TAG in; DRDY/TAG/DATA/MAERR out).
// - Per request: check the selector descriptor (valid, limit, alignment), translate it to a physical
//   64-bit word address, issue the read to an arbitrated SRAM port, and return data in request order.
// - MAERR is returned when a check fails. Sits between initiator cores and the local memory arbiter.

---
 rtl/neuro_mem_pkg.sv | 32 +++
 rtl/neuro_sel_table.sv | 28 ++
 rtl/neuro_mem_responder.sv | 130 +++++++++++++
 tb/tb_neuro_mem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neuro_mem_pkg.sv
// Shared types and widths for the Neuro32 tagged-read memory responder.
// Descriptor base is kept 34 bits wide so any RAM_AW up to 34 fits unchanged.
package neuro_mem_pkg;

  localparam int NM_SEL_W  = 3;
  localparam int NM_OFS_W  = 35;
  localparam int NM_LIM_W  = 32;
  localparam int NM_BASE_W = 34;
  localparam int NM_NDESC  = 1 << NM_SEL_W;

  typedef struct packed {
    logic [NM_SEL_W-1:0] sel;
    logic [NM_OFS_W-1:0] offset;
    logic                size;
    logic                tag;
  } neuro_req_t;

  typedef struct packed {
    logic vld;
    logic err;
    logic tag;
    logic size;
    logic odd;
  } neuro_trk_t;

  typedef struct packed {
    logic                 valid;
    logic [NM_BASE_W-1:0] base;
    logic [NM_LIM_W-1:0]  limit;
  } neuro_desc_t;

endpackage

// File: rtl/neuro_sel_table.sv
// Eight-entry selector descriptor file: one registered write port, one async read port.
// Reset clears every entry, which in particular invalidates all selectors.
module neuro_sel_table
  import neuro_mem_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [NM_SEL_W-1:0] wsel_i,
  input  neuro_desc_t         wdesc_i,
  input  logic [NM_SEL_W-1:0] rsel_i,
  output neuro_desc_t         rdesc_o
);

  neuro_desc_t table_q [NM_NDESC];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NM_NDESC; i++) table_q[i] <= '0;
    end else if (we_i) begin
      table_q[wsel_i] <= wdesc_i;
    end
  end

  // Async read: a same-cycle write is only visible after the edge.
  assign rdesc_o = table_q[rsel_i];

endmodule

// File: rtl/neuro_mem_responder.sv
// Tagged read responder: hold stage with descriptor checks, SRAM issue, in-order
// tracking pipe matched to the SRAM latency, and a registered response stage.
module neuro_mem_responder
  import neuro_mem_pkg::*;
#(
  parameter int RAM_AW  = 20,
  parameter int RAM_LAT = 2
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                ACT,
  output logic                NEXT,
  input  logic [NM_SEL_W-1:0] SEL,
  input  logic [NM_OFS_W-1:0] OFFSET,
  input  logic                SIZE,
  input  logic                TAGi,
  output logic                DRDY,
  output logic                TAGo,
  output logic [63:0]         DTo,
  output logic                MAERR,
  input  logic                CfgWE,
  input  logic [NM_SEL_W-1:0] CfgSEL,
  input  logic                CfgVALID,
  input  logic [RAM_AW-1:0]   CfgBASE,
  input  logic [NM_LIM_W-1:0] CfgLIMIT,
  input  logic                RamGNT,
  output logic                RamRD,
  output logic [RAM_AW-1:0]   RamADDR,
  input  logic [63:0]         RamQ
);

  neuro_req_t  hold_q, hold_d;
  logic        hv_q, hv_d;
  neuro_desc_t desc, cfgDesc;
  logic        err, issue, accept;
  logic [35:0] reqEnd;
  neuro_trk_t  trkIn, tail;
  neuro_trk_t  pipe_q [RAM_LAT];
  logic        drdy_q, maerr_q, tag_q;
  logic [63:0] dt_q, dt_d;

  assign cfgDesc = '{valid: CfgVALID, base: NM_BASE_W'(CfgBASE), limit: CfgLIMIT};

  neuro_sel_table u_sel_table (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .we_i    (CfgWE),
    .wsel_i  (CfgSEL),
    .wdesc_i (cfgDesc),
    .rsel_i  (hold_q.sel),
    .rdesc_o (desc)
  );

  // Checks in 36 bits so offsets at or above 2^32 can never wrap under the limit.
  assign reqEnd = {1'b0, hold_q.offset} + 36'(hold_q.size);
  assign err    = ~desc.valid | (hold_q.size & hold_q.offset[0]) | (reqEnd > {4'd0, desc.limit});
  assign issue  = hv_q & (err | RamGNT);
  assign NEXT   = ~hv_q | issue;
  assign accept = ACT & NEXT;

  assign RamRD   = hv_q & ~err;
  assign RamADDR = hv_q ? RAM_AW'(desc.base + NM_BASE_W'(hold_q.offset[NM_OFS_W-1:1])) : '0;

  always_comb begin
    hv_d   = hv_q;
    hold_d = hold_q;
    if (accept) begin
      hv_d   = 1'b1;
      hold_d = '{sel: SEL, offset: OFFSET, size: SIZE, tag: TAGi};
    end else if (issue) begin
      hv_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hv_q   <= 1'b0;
      hold_q <= '0;
    end else begin
      hv_q   <= hv_d;
      hold_q <= hold_d;
    end
  end

  // Errors ride the same pipe as reads so every response leaves in request order.
  always_comb begin
    trkIn = '0;
    if (issue) begin
      trkIn = '{vld: 1'b1, err: err, tag: hold_q.tag, size: hold_q.size, odd: hold_q.offset[0]};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < RAM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= trkIn;
      for (int i = 1; i < RAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail = pipe_q[RAM_LAT-1];

  always_comb begin
    dt_d = '0;
    if (tail.vld && !tail.err) begin
      dt_d = tail.size ? RamQ : {32'd0, (tail.odd ? RamQ[63:32] : RamQ[31:0])};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      drdy_q  <= 1'b0;
      maerr_q <= 1'b0;
      tag_q   <= 1'b0;
      dt_q    <= '0;
    end else begin
      drdy_q  <= tail.vld & ~tail.err;
      maerr_q <= tail.vld & tail.err;
      dt_q    <= dt_d;
      if (tail.vld) tag_q <= tail.tag;
    end
  end

  assign DRDY  = drdy_q;
  assign MAERR = maerr_q;
  assign TAGo  = tag_q;
  assign DTo   = dt_q;

endmodule

// File: tb/tb_neuro_mem_responder.sv
// Scoreboard bench for neuro_mem_responder: directed requests push expected responses,
// a negedge monitor pops and compares them, and a small SRAM model returns data.
module tb_neuro_mem_responder;

  localparam int AW  = 20;
  localparam int LAT = 2;

  logic          CLK, RESET, ACT, NEXT, SIZE, TAGi, DRDY, TAGo, MAERR;
  logic [2:0]    SEL, CfgSEL;
  logic [34:0]   OFFSET;
  logic [63:0]   DTo, RamQ;
  logic          CfgWE, CfgVALID, RamGNT, RamRD;
  logic [AW-1:0] CfgBASE, RamADDR;
  logic [31:0]   CfgLIMIT;

  typedef struct {
    logic        err;
    logic        tag;
    logic [63:0] data;
    int          acc;
    int          stall;
  } exp_t;

  typedef struct {
    logic [63:0] d;
    int          due;
  } rdata_t;

  exp_t          sbQ[$];
  logic [AW-1:0] addrQ[$];
  rdata_t        dataQ[$];
  logic [63:0]   ramMem [logic [AW-1:0]];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int waited;

  neuro_mem_responder #(.RAM_AW(AW), .RAM_LAT(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .ACT(ACT), .NEXT(NEXT), .SEL(SEL), .OFFSET(OFFSET),
    .SIZE(SIZE), .TAGi(TAGi), .DRDY(DRDY), .TAGo(TAGo), .DTo(DTo), .MAERR(MAERR),
    .CfgWE(CfgWE), .CfgSEL(CfgSEL), .CfgVALID(CfgVALID), .CfgBASE(CfgBASE),
    .CfgLIMIT(CfgLIMIT), .RamGNT(RamGNT), .RamRD(RamRD), .RamADDR(RamADDR), .RamQ(RamQ)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // SRAM model: a granted read seen mid-cycle returns its word LAT cycles later.
  initial forever begin
    @(negedge CLK);
    if (!RESET && RamRD && RamGNT) begin
      checkOutput("ramrd_expected", 64'(addrQ.size() != 0), 64'd1);
      if (addrQ.size() != 0) checkOutput("ram_addr", 64'(RamADDR), 64'(addrQ.pop_front()));
      dataQ.push_back('{d: (ramMem.exists(RamADDR) ? ramMem[RamADDR] : 64'hBAD0_BAD0_BAD0_BAD0),
                        due: cyc + LAT});
    end
  end

  initial forever begin
    @(posedge CLK);
    #1;
    if (dataQ.size() != 0 && dataQ[0].due == cyc) RamQ = dataQ.pop_front().d;
    else RamQ = 64'hDEAD_DEAD_DEAD_DEAD;
  end

  // Response monitor.
  initial forever begin
    @(negedge CLK);
    if (DRDY || MAERR) begin
      checkOutput("response_expected", 64'(sbQ.size() != 0), 64'd1);
      if (sbQ.size() != 0) begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("resp_kind", 64'({DRDY, MAERR}), (e.err ? 64'd1 : 64'd2));
        checkOutput("resp_tag", 64'(TAGo), 64'(e.tag));
        checkOutput("resp_data", DTo, e.data);
        if (e.stall >= 0) checkOutput("resp_latency", 64'(cyc), 64'(e.acc + LAT + 2 + e.stall));
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] sel, input logic [34:0] ofs, input logic size,
                               input logic tag, input logic expErr, input logic [AW-1:0] expAddr,
                               input logic [63:0] expData, input int stall, output int wcnt);
    ACT = 1'b1; SEL = sel; OFFSET = ofs; SIZE = size; TAGi = tag;
    wcnt = 0;
    @(negedge CLK);
    while (!NEXT && wcnt < 40) begin
      wcnt++;
      @(negedge CLK);
    end
    if (!NEXT) begin
      checkOutput("accept_timeout", 64'(NEXT), 64'd1);
      ACT = 1'b0;
      tick();
      return;
    end
    sbQ.push_back('{err: expErr, tag: tag, data: (expErr ? 64'd0 : expData), acc: cyc, stall: stall});
    if (!expErr) addrQ.push_back(expAddr);
    tick();
  endtask

  task automatic idle();
    ACT = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (sbQ.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    checkOutput("drain_empty", 64'(sbQ.size()), 64'd0);
    repeat (2) tick();
  endtask

  task automatic writeDesc(input logic [2:0] sel, input logic v, input logic [AW-1:0] base,
                           input logic [31:0] lim);
    CfgWE = 1'b1; CfgSEL = sel; CfgVALID = v; CfgBASE = base; CfgLIMIT = lim;
    tick();
    CfgWE = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tagName);
    @(negedge CLK);
    checkOutput({tagName, "_next"},  64'(NEXT),    64'd1);
    checkOutput({tagName, "_drdy"},  64'(DRDY),    64'd0);
    checkOutput({tagName, "_maerr"}, 64'(MAERR),   64'd0);
    checkOutput({tagName, "_tago"},  64'(TAGo),    64'd0);
    checkOutput({tagName, "_dto"},   DTo,          64'd0);
    checkOutput({tagName, "_ramrd"}, 64'(RamRD),   64'd0);
    checkOutput({tagName, "_raddr"}, 64'(RamADDR), 64'd0);
    tick();
  endtask

  task automatic stallControl();
    int w = 0;
    @(negedge CLK);
    while (!RamRD && w < 20) begin
      w++;
      @(negedge CLK);
    end
    for (int k = 0; k < 3; k++) begin
      checkOutput("stall_next",  64'(NEXT),    64'd0);
      checkOutput("stall_ramrd", 64'(RamRD),   64'd1);
      checkOutput("stall_addr",  64'(RamADDR), 64'h110);
      if (k < 2) @(negedge CLK);
    end
    @(posedge CLK);
    #1;
    RamGNT = 1'b1;
  endtask

  initial begin
    RESET = 1'b1; ACT = 1'b0; SEL = '0; OFFSET = '0; SIZE = 1'b0; TAGi = 1'b0;
    CfgWE = 1'b0; CfgSEL = '0; CfgVALID = 1'b0; CfgBASE = '0; CfgLIMIT = '0;
    RamGNT = 1'b1; RamQ = '0;
    repeat (3) tick();
    checkIdleOutputs("reset");
    RESET = 1'b0;
    tick();

    writeDesc(3'd0, 1'b1, 20'h100, 32'hFF);

    // Single 64-bit read with the reference latency.
    ramMem[20'h108] = 64'hA5;
    applyStimulus(3'd0, 35'h10, 1'b1, 1'b0, 1'b0, 20'h108, 64'hA5, 0, waited);
    drain();

    // Back-to-back 32-bit halves.
    ramMem[20'h108] = 64'h1111_2222_3333_4444;
    applyStimulus(3'd0, 35'h11, 1'b0, 1'b1, 1'b0, 20'h108, 64'h1111_2222, 0, waited);
    applyStimulus(3'd0, 35'h10, 1'b0, 1'b1, 1'b0, 20'h108, 64'h3333_4444, 0, waited);
    checkOutput("b2b_next_wait", 64'(waited), 64'd0);
    drain();

    // Errors interleaved with limit-boundary successes.
    ramMem[20'h17F] = 64'hCAFE_BABE_1234_5678;
    applyStimulus(3'd0, 35'hFF, 1'b0, 1'b0, 1'b0, 20'h17F, 64'hCAFE_BABE, 0, waited);
    applyStimulus(3'd0, 35'h11, 1'b1, 1'b1, 1'b1, 20'h0, 64'h0, 0, waited);
    applyStimulus(3'd0, 35'h100, 1'b0, 1'b0, 1'b1, 20'h0, 64'h0, 0, waited);
    applyStimulus(3'd0, 35'hFE, 1'b1, 1'b1, 1'b0, 20'h17F, 64'hCAFE_BABE_1234_5678, 0, waited);
    applyStimulus(3'd3, 35'h10, 1'b0, 1'b0, 1'b1, 20'h0, 64'h0, 0, waited);
    applyStimulus(3'd0, 35'h4_0000_0000, 1'b0, 1'b1, 1'b1, 20'h0, 64'h0, 0, waited);
    drain();

    // Grant stalled three cycles on the first of ok, err, ok.
    ramMem[20'h110] = 64'hDEAD_BEEF_0BAD_F00D;
    RamGNT = 1'b0;
    fork
      begin
        applyStimulus(3'd0, 35'h20, 1'b0, 1'b1, 1'b0, 20'h110, 64'h0BAD_F00D, 3, waited);
        applyStimulus(3'd0, 35'h100, 1'b0, 1'b0, 1'b1, 20'h0, 64'h0, 0, waited);
        applyStimulus(3'd0, 35'h21, 1'b0, 1'b1, 1'b0, 20'h110, 64'hDEAD_BEEF, 0, waited);
        idle();
      end
      stallControl();
    join
    drain();

    // Descriptor rewrite in the check cycle uses the old limit.
    applyStimulus(3'd0, 35'h20, 1'b0, 1'b0, 1'b0, 20'h110, 64'h0BAD_F00D, 0, waited);
    idle();
    writeDesc(3'd0, 1'b1, 20'h100, 32'h0F);
    applyStimulus(3'd0, 35'h20, 1'b0, 1'b1, 1'b1, 20'h0, 64'h0, 0, waited);
    drain();

    // Reset with two responses in flight.
    writeDesc(3'd0, 1'b1, 20'h100, 32'hFF);
    ramMem[20'h108] = 64'h5555_6666_7777_8888;
    applyStimulus(3'd0, 35'h10, 1'b1, 1'b1, 1'b0, 20'h108, 64'h5555_6666_7777_8888, 0, waited);
    applyStimulus(3'd0, 35'h11, 1'b0, 1'b0, 1'b0, 20'h108, 64'h5555_6666, 0, waited);
    idle();
    RESET = 1'b1;
    sbQ.delete();
    addrQ.delete();
    dataQ.delete();
    tick();
    checkIdleOutputs("flush");
    RESET = 1'b0;
    repeat (8) tick();
    checkIdleOutputs("post_flush");
    applyStimulus(3'd0, 35'h10, 1'b1, 1'b1, 1'b1, 20'h0, 64'h0, 0, waited);
    drain();

    checkOutput("addr_queue_empty", 64'(addrQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
